// File: rtl/tt_load_drain_ctrl.sv
// Load-queue drain controller: walks the circular LQ from a start id, hands each
// committed entry to VRF writeback and pulses an LQ-commit back to the scoreboard.
//
// Writeback handshake: o_wb_valid is asserted only while draining, when the entry
// at ptr has data and the block is not flushing. A transfer happens on any cycle
// with o_wb_valid & i_wb_ready. Once raised, o_wb_valid and o_wb_lqid hold until
// that transfer.
module tt_load_drain_ctrl #(
  parameter int LQ_DEPTH = 8,
  parameter int CNT_W    = 3,
  parameter int LQID_W   = $clog2(LQ_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_drain_req,
  input  logic [CNT_W-1:0]  i_drain_ref_count,
  input  logic [LQID_W-1:0] i_drain_lqid_start,
  output logic              o_draining,
  input  logic [LQ_DEPTH-1:0] i_lq_data_valid,
  input  logic              i_flush,
  output logic              o_wb_valid,
  input  logic              i_wb_ready,
  output logic [LQID_W-1:0] o_wb_lqid,
  output logic              o_wb_last,
  output logic              o_lq_commit,
  output logic [LQID_W-1:0] o_dest_lqid,
  output logic              dbg_state
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t            state;
  logic [LQID_W-1:0] ptr;
  logic [CNT_W-1:0]  remaining;
  logic              active;
  logic              fire;

  // A zero-count drain sits in DRAIN with remaining==0 and never requests writeback.
  assign active      = (state == DRAIN) && (remaining != '0) && !i_flush;
  assign o_wb_valid  = active && i_lq_data_valid[ptr];
  assign fire        = o_wb_valid && i_wb_ready;
  assign o_lq_commit = fire;
  assign o_wb_lqid   = ptr;
  assign o_dest_lqid = ptr;
  assign o_wb_last   = (state == DRAIN) && (remaining == CNT_W'(1));
  assign o_draining  = (state == DRAIN);
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
    end else if (i_flush) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_drain_req) begin
            ptr       <= i_drain_lqid_start;
            remaining <= i_drain_ref_count;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (remaining == '0) begin
            state <= IDLE;
          end else if (fire) begin
            ptr       <= ptr + LQID_W'(1);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_load_drain_ctrl.sv
// Directed bench for tt_load_drain_ctrl: inputs change on the falling edge,
// outputs are sampled shortly after, and a commit monitor checks retired ids in order.
module tb_tt_load_drain_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_drain_req;
  logic [2:0] i_drain_ref_count;
  logic [2:0] i_drain_lqid_start;
  logic       o_draining;
  logic [7:0] i_lq_data_valid;
  logic       i_flush;
  logic       o_wb_valid;
  logic       i_wb_ready;
  logic [2:0] o_wb_lqid;
  logic       o_wb_last;
  logic       o_lq_commit;
  logic [2:0] o_dest_lqid;
  logic       dbg_state;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  tt_load_drain_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .i_drain_req(i_drain_req), .i_drain_ref_count(i_drain_ref_count),
    .i_drain_lqid_start(i_drain_lqid_start), .o_draining(o_draining),
    .i_lq_data_valid(i_lq_data_valid), .i_flush(i_flush),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_lqid(o_wb_lqid),
    .o_wb_last(o_wb_last), .o_lq_commit(o_lq_commit), .o_dest_lqid(o_dest_lqid),
    .dbg_state(dbg_state)
  );

  // clock / reset: rising edges at 10,30,50...; falling edges at 20,40...
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic drn, input logic vld,
                            input logic [2:0] id, input logic lst, input logic cmt);
    check({tag, "_draining"}, o_draining, drn);
    check({tag, "_wb_valid"}, o_wb_valid, vld);
    check({tag, "_wb_lqid"},  o_wb_lqid,  id);
    check({tag, "_wb_last"},  o_wb_last,  lst);
    check({tag, "_commit"},   o_lq_commit, cmt);
  endtask

  // driver: present a drain request on the next falling edge
  task automatic drive_req(input logic [2:0] start, input logic [2:0] cnt);
    @(negedge clk);
    i_drain_req = 1'b1;
    i_drain_lqid_start = start;
    i_drain_ref_count = cnt;
    #1;
    check("req_idle_draining", o_draining, 1'b0);
    check("req_idle_wb_valid", o_wb_valid, 1'b0);
  endtask

  // scoreboard: every commit must match the head of exp_q
  always @(negedge clk) begin
    #3;
    if (o_lq_commit) begin
      if (exp_q.size() == 0) check("unexpected_commit", {29'd0, o_dest_lqid}, 32'hFFFF_FFFF);
      else check("commit_id", o_dest_lqid, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    i_drain_req = 1'b0; i_drain_ref_count = 3'd0; i_drain_lqid_start = 3'd0;
    i_lq_data_valid = 8'h00; i_flush = 1'b0; i_wb_ready = 1'b0;
    #2;
    check_outs("reset", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("reset_dest", o_dest_lqid, 3'd0);
    @(negedge clk); reset_n = 1'b1;

    // basic drain: start 2, count 3
    exp_q.push_back(3'd2); exp_q.push_back(3'd3); exp_q.push_back(3'd4);
    i_lq_data_valid = 8'hFF; i_wb_ready = 1'b1;
    drive_req(3'd2, 3'd3);
    @(negedge clk); i_drain_req = 1'b0; #1;
    check_outs("basic_c1", 1'b1, 1'b1, 3'd2, 1'b0, 1'b1);
    @(negedge clk); #1;
    check_outs("basic_c2", 1'b1, 1'b1, 3'd3, 1'b0, 1'b1);
    @(negedge clk); #1;
    check_outs("basic_c3", 1'b1, 1'b1, 3'd4, 1'b1, 1'b1);
    @(negedge clk); #1;
    check_outs("basic_c4", 1'b0, 1'b0, 3'd5, 1'b0, 1'b0);

    // wrap-around: 6,7,0,1
    exp_q.push_back(3'd6); exp_q.push_back(3'd7); exp_q.push_back(3'd0); exp_q.push_back(3'd1);
    drive_req(3'd6, 3'd4);
    @(negedge clk); i_drain_req = 1'b0; #1;
    check_outs("wrap_c1", 1'b1, 1'b1, 3'd6, 1'b0, 1'b1);
    @(negedge clk); #1;
    check_outs("wrap_c2", 1'b1, 1'b1, 3'd7, 1'b0, 1'b1);
    @(negedge clk); #1;
    check_outs("wrap_c3", 1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
    @(negedge clk); #1;
    check_outs("wrap_c4", 1'b1, 1'b1, 3'd1, 1'b1, 1'b1);
    @(negedge clk); #1;
    check("wrap_done_draining", o_draining, 1'b0);

    // stalls: data for entry 0 late by 3 cycles, ready low 2 cycles on entry 1
    exp_q.push_back(3'd0); exp_q.push_back(3'd1);
    i_lq_data_valid = 8'h00;
    drive_req(3'd0, 3'd2);
    @(negedge clk); i_drain_req = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      check_outs("stall_data", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    end
    @(negedge clk); i_lq_data_valid = 8'h01; #1;
    check_outs("stall_e0_fire", 1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); i_lq_data_valid = 8'h03; i_wb_ready = 1'b0; #1;
      check_outs("stall_ready", 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
    end
    @(negedge clk); i_wb_ready = 1'b1; #1;
    check_outs("stall_e1_fire", 1'b1, 1'b1, 3'd1, 1'b1, 1'b1);
    @(negedge clk); #1;
    check("stall_done_draining", o_draining, 1'b0);

    // zero count
    i_lq_data_valid = 8'hFF;
    drive_req(3'd5, 3'd0);
    @(negedge clk); i_drain_req = 1'b0; #1;
    check("zero_c1_draining", o_draining, 1'b1);
    check("zero_c1_wb_valid", o_wb_valid, 1'b0);
    check("zero_c1_commit", o_lq_commit, 1'b0);
    @(negedge clk); #1;
    check("zero_c2_draining", o_draining, 1'b0);
    check("zero_c2_wb_valid", o_wb_valid, 1'b0);

    // back-to-back: request held across two instructions
    exp_q.push_back(3'd1); exp_q.push_back(3'd3); exp_q.push_back(3'd4);
    drive_req(3'd1, 3'd1);
    @(negedge clk); i_drain_lqid_start = 3'd3; i_drain_ref_count = 3'd2; #1;
    check_outs("b2b_first", 1'b1, 1'b1, 3'd1, 1'b1, 1'b1);
    @(negedge clk); #1;
    check_outs("b2b_gap", 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
    @(negedge clk); i_drain_req = 1'b0; #1;
    check_outs("b2b_s1", 1'b1, 1'b1, 3'd3, 1'b0, 1'b1);
    @(negedge clk); #1;
    check_outs("b2b_s2", 1'b1, 1'b1, 3'd4, 1'b1, 1'b1);
    @(negedge clk); #1;
    check("b2b_done_draining", o_draining, 1'b0);

    // back-to-back with flush on the first fire of the second instruction
    exp_q.push_back(3'd1);
    drive_req(3'd1, 3'd1);
    @(negedge clk); i_drain_lqid_start = 3'd3; i_drain_ref_count = 3'd2; #1;
    check_outs("fl_first", 1'b1, 1'b1, 3'd1, 1'b1, 1'b1);
    @(negedge clk); #1;
    check("fl_gap_draining", o_draining, 1'b0);
    @(negedge clk); i_drain_req = 1'b0; i_flush = 1'b1; #1;
    check("fl_flush_draining", o_draining, 1'b1);
    check("fl_flush_wb_valid", o_wb_valid, 1'b0);
    check("fl_flush_commit", o_lq_commit, 1'b0);
    @(negedge clk); i_flush = 1'b0; #1;
    check("fl_after_draining", o_draining, 1'b0);
    check("fl_after_wb_valid", o_wb_valid, 1'b0);
    check("fl_after_commit", o_lq_commit, 1'b0);

    // asynchronous reset mid-drain, between clock edges
    exp_q.push_back(3'd0); exp_q.push_back(3'd1);
    drive_req(3'd0, 3'd3);
    @(negedge clk); i_drain_req = 1'b0; #1;
    check("ar_c1_lqid", o_wb_lqid, 3'd0);
    @(negedge clk); #1;
    check_outs("ar_c2", 1'b1, 1'b1, 3'd1, 1'b0, 1'b1);
    #4; reset_n = 1'b0; #1;
    check_outs("ar_reset", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("ar_reset_dest", o_dest_lqid, 3'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); #5;

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_load_drain_ctrl.md
# tt_load_drain_ctrl

Drains vector load-queue entries into vector register file writeback for one load instruction at a time. It sits directly downstream of the OVI scoreboard's drain interface and consumes its drain request, reference count and starting LQ id. It walks the 8-entry circular load queue in order. Each committed entry is handed to the VRF writeback port, and the block returns the LQ-commit pulse that decrements the scoreboard reference count.

## Interface
Parameters:
- LQ_DEPTH, 8, load-queue entries; power of two; LQID width is log2(LQ_DEPTH) = 3
- CNT_W, 3, width of drain reference count

Ports:
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  reset, asynchronous and active-low
- i_drain_req  in  1  scoreboard drain request (o_drain_load_buffer)
- i_drain_ref_count  in  3  entries to drain for the selected instruction
- i_drain_lqid_start  in  3  LQ id of the instruction's first entry
- o_draining  out  1  block busy; drives scoreboard i_draining_load_buffer
- i_lq_data_valid  in  8  per-entry flag: load data for that LQ slot has arrived
- i_flush  in  1  synchronous abort of the current drain (pipeline kill)
- o_wb_valid  out  1  writeback request for entry o_wb_lqid
- i_wb_ready  in  1  VRF writeback accepts this cycle
- o_wb_lqid  out  3  LQ id being written back
- o_wb_last  out  1  the current entry is the last of this instruction
- o_lq_commit  out  1  entry retired; drives scoreboard i_lq_commit and LQ free
- o_dest_lqid  out  3  id of the retired entry; drives scoreboard i_dest_lqid

## Operation
- FSM states: IDLE, DRAIN.
- Registers:
  - ptr[2:0]: current LQ id.
  - remaining[2:0]: entries left to drain.
- IDLE:
  - Acceptance condition: i_drain_req=1 and state==IDLE (o_draining=0).
  - On acceptance: ptr<=i_drain_lqid_start, remaining<=i_drain_ref_count, state<=DRAIN.
  - The scoreboard marks the entry drained on the same edge, so the request for that instruction is gone on the next cycle.
- DRAIN:
  - o_wb_valid = i_lq_data_valid[ptr].
  - o_wb_lqid = ptr.
  - o_wb_last = (remaining==1).
  - Handshake fire = o_wb_valid & i_wb_ready.
- On fire:
  - o_lq_commit=1 and o_dest_lqid=ptr in the same cycle.
  - ptr<=ptr+1, mod 8 (7 wraps to 0).
  - remaining<=remaining-1.
  - If remaining==1, state<=IDLE.
- Zero count: acceptance with i_drain_ref_count==0 enters DRAIN, which exits to IDLE on the next edge with no writeback or commit. o_draining is high for exactly one cycle.
- Stall: o_wb_valid stays low while i_lq_data_valid[ptr]==0. The block waits indefinitely with no timeout.
- Once o_wb_valid=1, o_wb_lqid must hold until fire. A producer that has set the data-valid flag must not drop it before commit.
- i_flush=1:
  - state<=IDLE and remaining<=0.
  - o_wb_valid and o_lq_commit are forced to 0 in that cycle.
  - Flush wins over a simultaneous acceptance or fire.
- Simultaneous last fire and new i_drain_req: the request is not accepted that cycle because o_draining=1. It is accepted on the next cycle from IDLE.
- Arithmetic: ptr and remaining are unsigned 3-bit. Decrement below 0 is unreachable because exit occurs at 1.

## Timing
- Reset (async assert, sync release): state=IDLE, ptr=0, remaining=0.
- Output values under reset: o_draining=0, o_wb_valid=0, o_wb_lqid=0, o_wb_last=0, o_lq_commit=0, o_dest_lqid=0.
- Reset asserted mid-drain abandons the drain immediately; there is no commit in that cycle.
- o_draining is registered: (state==DRAIN). It rises the cycle after acceptance.
- Latency from acceptance to the first possible commit: 1 cycle, given data valid and ready.
- Throughput: one commit per cycle. N entries with data present and ready held high complete in N cycles after entering DRAIN.
- o_wb_valid, o_wb_last, o_lq_commit and o_dest_lqid are combinational from state and registers plus i_lq_data_valid, i_wb_ready and i_flush. There is no combinational path from i_drain_req to any output.

## Test plan
- Basic drain: reset; req with lqid_start=2, count=3; all data valid; ready=1.
  - Expect commits on LQ ids 2,3,4 on cycles 1,2,3 after acceptance.
  - o_wb_last only on 4; o_draining=0 on cycle 4.
- Wrap-around: start=6, count=4, all valid.
  - Expect commit ids 6,7,0,1 in order with no gaps.
- Stalls: start=0, count=2; data valid for entry 0 arrives 3 cycles late; ready low 2 cycles on entry 1.
  - Expect o_wb_lqid stable through each stall and exactly 2 commits.
  - No commit while valid=0 or ready=0.
- Zero count: req with count=0.
  - Expect o_draining high for exactly 1 cycle, then low.
  - No o_wb_valid and no o_lq_commit at any point.
- Back-to-back and flush, part 1: req held high across two instructions (start=1 count=1, then start=3 count=2).
  - Expect the second acceptance the cycle after the first returns to IDLE, with commits 1, then 3,4.
- Back-to-back and flush, part 2: repeat with i_flush pulsed during the first fire of the second instruction.
  - Expect no commit that cycle, IDLE next cycle and o_draining=0.
- Async reset: assert reset_n=0 mid-drain between clock edges.
  - Expect all outputs 0 immediately, without waiting for a clock edge.
